// File: rtl/divider_8b_pkg.sv
// Shared definitions for the 8-bit by 4-bit restoring divider.
//   DIVIDEND_W / DIVISOR_W : operand widths (8-bit dividend, 4-bit divisor)
//   REM_W                  : partial remainder width (one guard bit above the divisor)
//   CNT_W                  : iteration counter width (8 steps)
//   DIV_ZERO_Q             : quotient reported for a zero divisor
//   state_t                : controller states
//   black_cell/grey_cell   : parallel-prefix carry cells used by the trial subtractor
package divider_8b_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int REM_W      = DIVISOR_W + 1;
  localparam int CNT_W      = 3;

  localparam logic [DIVIDEND_W-1:0] DIV_ZERO_Q = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Black cell: merges two (generate, propagate) groups, returns {g, p}.
  function automatic logic [1:0] black_cell(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  // Grey cell: merges a group with a fully resolved carry, returns the carry.
  function automatic logic grey_cell(input logic g_hi, input logic p_hi, input logic c_lo);
    return g_hi | (p_hi & c_lo);
  endfunction

endpackage

// File: rtl/divider_sub.sv
// 5-bit combinational trial subtractor: diff = a - b, computed as a + ~b + 1
// with a Kogge-Stone style carry tree built from black/grey prefix cells.
//   a         : shifted partial remainder
//   b         : zero-extended divisor
//   diff      : a - b (meaningful when no_borrow = 1)
//   no_borrow : 1 when a >= b (carry out of the add-complement)
module divider_sub
  import divider_8b_pkg::*;
(
  input  logic [REM_W-1:0] a,
  input  logic [REM_W-1:0] b,
  output logic [REM_W-1:0] diff,
  output logic             no_borrow
);

  logic [REM_W-1:0] g;      // bit generate for a + ~b
  logic [REM_W-1:0] p;      // bit propagate for a + ~b
  logic [REM_W:0]   c;      // carry into each bit, c[REM_W] is the carry out
  logic [4:1]       g_l1;   // span-2 groups [k:k-1]
  logic [4:1]       p_l1;
  logic [4:3]       g_l2;   // span-4 groups [k:k-3]
  logic [4:3]       p_l2;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // The +1 of the two's complement enters as the carry into bit 0.
  assign c[0] = 1'b1;

  // Level 1: span 2
  assign c[1] = grey_cell(g[0], p[0], c[0]);
  assign {g_l1[1], p_l1[1]} = black_cell(g[1], p[1], g[0], p[0]);
  assign {g_l1[2], p_l1[2]} = black_cell(g[2], p[2], g[1], p[1]);
  assign {g_l1[3], p_l1[3]} = black_cell(g[3], p[3], g[2], p[2]);
  assign {g_l1[4], p_l1[4]} = black_cell(g[4], p[4], g[3], p[3]);

  // Level 2: span 4
  assign c[2] = grey_cell(g_l1[1], p_l1[1], c[0]);
  assign c[3] = grey_cell(g_l1[2], p_l1[2], c[1]);
  assign {g_l2[3], p_l2[3]} = black_cell(g_l1[3], p_l1[3], g_l1[1], p_l1[1]);
  assign {g_l2[4], p_l2[4]} = black_cell(g_l1[4], p_l1[4], g_l1[2], p_l1[2]);

  // Level 3: span 8, all carries resolved
  assign c[4] = grey_cell(g_l2[3], p_l2[3], c[0]);
  assign c[5] = grey_cell(g_l2[4], p_l2[4], c[1]);

  assign diff      = p ^ c[REM_W-1:0];
  assign no_borrow = c[REM_W];

endmodule

// File: rtl/divider_8b.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per cycle.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request; x and y are sampled on the accepting edge (IDLE or FIN)
//   x, y     : dividend (8 bits) and divisor (4 bits), unsigned
//   q, r     : quotient and remainder, valid while done = 1 and held afterwards
//   busy     : high while the 8 division steps run
//   done     : one-cycle result pulse
//   div_zero : set with done when y = 0 (q = 8'hFF, r = x[3:0])
module divider_8b
  import divider_8b_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] x,
  input  logic [DIVISOR_W-1:0]  y,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  state_t                state;
  state_t                state_nxt;
  logic [DIVIDEND_W-1:0] x_lat;
  logic [DIVISOR_W-1:0]  y_lat;
  logic [REM_W-1:0]      rem;
  logic [REM_W-1:0]      rem5;
  logic [REM_W-1:0]      diff;
  logic [REM_W-1:0]      rem_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] q_sr;
  logic [DIVIDEND_W-1:0] q_sr_nxt;
  logic                  no_borrow;
  logic                  accept;
  logic                  y_is_zero;
  logic                  last_step;
  logic                  unused_rem_msb;

  // A new request is only taken outside RUN, so a running division is never disturbed.
  assign accept    = start && (state != RUN);
  assign y_is_zero = (y == '0);
  assign last_step = (cnt == CNT_W'(DIVIDEND_W - 1));

  // Bring down the next dividend bit, MSB first.
  assign rem5 = {rem[DIVISOR_W-1:0], x_lat[CNT_W'(DIVIDEND_W - 1) - cnt]};

  // rem < y before every shift, so the stored remainder MSB is always 0 and
  // only the low bits feed the next shift.
  assign unused_rem_msb = rem[REM_W-1];

  divider_sub u_sub (
    .a         (rem5),
    .b         ({1'b0, y_lat}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // Restoring step: keep the difference only when the trial subtraction fits.
  assign rem_nxt  = no_borrow ? diff : rem5;
  assign q_sr_nxt = {q_sr[DIVIDEND_W-2:0], no_borrow};

  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (accept) begin
          state_nxt = y_is_zero ? FIN : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = FIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lat    <= '0;
      y_lat    <= '0;
      rem      <= '0;
      cnt      <= '0;
      q_sr     <= '0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      x_lat    <= x;
      y_lat    <= y;
      rem      <= '0;
      cnt      <= '0;
      q_sr     <= '0;
      div_zero <= y_is_zero;
      // Zero divisor resolves immediately; otherwise q/r keep the previous
      // result until the 8th step overwrites them.
      if (y_is_zero) begin
        q <= DIV_ZERO_Q;
        r <= x[DIVISOR_W-1:0];
      end
    end else if (state == RUN) begin
      rem  <= rem_nxt;
      q_sr <= q_sr_nxt;
      cnt  <= cnt + CNT_W'(1);
      if (last_step) begin
        q <= q_sr_nxt;
        r <= rem_nxt[DIVISOR_W-1:0];
      end
    end
  end

endmodule

// File: doc/divider_8b.md
DIVIDER_8B -- requirements
Module: divider_8b

Interface
REQ-001 Parameter: none; widths fixed at 8-bit dividend, 4-bit divisor, to match the 4b multiplier product/operand widths.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; samples x,y on the accepting edge.
REQ-005 x  input  8  dividend (unsigned).
REQ-006 y  input  4  divisor (unsigned).
REQ-007 q  output  8  quotient; valid while done=1, held until next accepted start.
REQ-008 r  output  4  remainder; valid while done=1, held until next accepted start.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse; result valid.
REQ-011 div_zero  output  1  high with done when y=0; held with q/r.

Function
REQ-012 FSM states: IDLE, RUN, FIN; encoding free.
REQ-013 start is accepted only in IDLE or FIN; on acceptance, latch x and y, clear the 5-bit partial remainder and the iteration counter.
REQ-014 From IDLE or FIN, an accepted start with y/=0 enters RUN; with y=0 it enters FIN directly with q=8'hFF, r=x[3:0], div_zero=1.
REQ-015 start in RUN is ignored; latched operands are not disturbed.
REQ-016 RUN performs one restoring step per cycle, MSB first: rem5 = {rem[3:0], x_bit}; if rem5 >= {1'b0,y}, rem = rem5 - y and q_bit = 1, else rem = rem5 and q_bit = 0.
REQ-017 Partial remainder is 5 bits wide; never overflows because rem < y <= 15 before each shift.
REQ-018 3-bit counter counts the 8 iterations; after the 8th step, state goes to FIN.
REQ-019 Latency: start accepted at edge k, result valid and done=1 after edge k+8 (y/=0) or after edge k+1 (y=0).
REQ-020 done=1 only during the FIN cycle; FIN returns to IDLE on the next edge unless start is accepted (back-to-back allowed).
REQ-021 busy=1 exactly in RUN; busy and done are never both high.
REQ-022 Results satisfy x = q*y + r and r < y for every y/=0.
REQ-023 div_zero clears on the next accepted start with y/=0.

Reset
REQ-024 rst asserted at any time, including mid-RUN, forces state IDLE, q=0, r=0, busy=0, done=0, div_zero=0, counter=0, remainder=0, without waiting for a clock edge.
REQ-025 The first accepted start after rst deasserts begins a clean division; no partial result from the aborted division survives.

Structure
REQ-026 Shared package holds DIVIDEND_W=8, DIVISOR_W=4, the FSM state type, and the divide-by-zero quotient constant 8'hFF.
REQ-027 One sub-module, divider_sub: a 5-bit combinational trial subtractor producing difference and a no-borrow flag (no-borrow = rem5 >= y). It uses the same GREY/BLACK prefix-cell style as the existing adder.
REQ-028 The top level is limited to registers, the FSM, the counter, and the quotient shift register.

Verification
REQ-029 x=200, y=13, start at edge k -> done after edge k+8, q=15, r=5, div_zero=0; busy high for 8 cycles.
REQ-030 x=255, y=1 -> q=255, r=0; x=7, y=9 -> q=0, r=7.
REQ-031 x=8'h5A, y=0 -> after edge k+1: done=1, q=8'hFF, r=4'hA, div_zero=1; busy never high.
REQ-032 Divide 100/7. Pulse start with x=3, y=2 at cycle 4 of RUN -> it is ignored, result q=14, r=2. Then start in the FIN cycle with 9/4 -> back-to-back result q=2, r=1.
REQ-033 Assert rst asynchronously mid-RUN (between edges) -> all outputs 0 immediately. Release, then divide 50/6 -> q=8, r=2.
REQ-034 Exhaustive sweep of all 4096 (x,y) pairs with a self-checking model. Check REQ-022 for y/=0, REQ-014 for y=0, and the latency of REQ-019.
